mul_sequencer: RTL and testbench

Multi-cycle shift-add multiplier sequencer for the LEGv8 execute stage, serving MUL (low N bits of the product) and UMULH (high N bits, unsigned). Once the execute stage hands over operands it runs one add/shift step per clock and exits early when the remaining multiplier bits are zero. While it runs it raises `busy`, which the hazard logic uses to stall the pipeline. Each result is published with a one-cycle `done` pulse.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 101 ++++++++++
 tb/tb_mul_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Handshake/data bundle between the execute stage and the shift-add multiplier.
// Latency: none (wires only); the sequencer registers everything it drives.
// Backpressure: busy tells the issuing side to stall; start during busy is dropped.
// Ports: start/mulHigh/opA/opB/flush flow master->slave, busy/done/result slave->master.
interface mul_sequencer_if #(
    parameter int N = 64
);
    logic         start;
    logic         mulHigh;
    logic [N-1:0] opA;
    logic [N-1:0] opB;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, mulHigh, opA, opB, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, mulHigh, opA, opB, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier sequencer for MUL (low half) and UMULH (high half, unsigned).
// Latency: r+1 cycles from accept to done, r = max(1, msb index of opB + 1) <= N.
// Backpressure: busy high while running; start in RUN is ignored, flush aborts.
// Ports: clk (rising edge), reset (async active-low), bus (slave modport of mul_sequencer_if).
module mul_sequencer #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           reset,
    mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic             hisel_q, hisel_d;
    logic [N-1:0]     result_q, result_d;

    logic             accept;
    logic [2*N-1:0]   acc_step;
    logic [N-1:0]     mplier_shr;

    // A request is only taken when the sequencer is free; flush beats start.
    assign accept     = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);
    assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_shr = mplier_q >> 1;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hisel_d  = hisel_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (mplier_shr == '0) begin
                    // Early exit: no multiplier bits left. The result is captured
                    // on this edge so it is already valid during the done cycle.
                    state_d  = DONE;
                    result_d = hisel_q ? acc_step[2*N-1:N] : acc_step[N-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides the IDLE/DONE fall-through so back-to-back requests
        // go straight from DONE into RUN without an idle bubble.
        if (accept) begin
            state_d  = RUN;
            mcand_d  = {{N{1'b0}}, bus.opA};
            mplier_d = bus.opB;
            acc_d    = '0;
            hisel_d  = bus.mulHigh;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hisel_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hisel_q  <= hisel_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
    localparam int N = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mul_sequencer_if #(.N(N)) bus_if ();

    mul_sequencer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         hi;
        logic [N-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-width unsigned product, half selected by hi.
    function automatic logic [N-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic hi);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return hi ? p[2*N-1:N] : p[N-1:0];
    endfunction

    // Reference: number of RUN cycles depends only on opB's highest set bit.
    function automatic int ref_lat(input logic [N-1:0] b);
        int r;
        r = 1;
        for (int i = 0; i < N; i++) if (b[i]) r = i + 1;
        return r;
    endfunction

    // Issue a request and wait for done; checks busy width, latency and result.
    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic hi, input logic [N-1:0] exp_res, input int exp_lat);
        int  lat;
        bit  got;
        bit  busy_ok;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.opA = a; bus_if.opB = b; bus_if.mulHigh = hi;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = 0; got = 0; busy_ok = 1;
        for (int c = 0; c < N + 10; c++) begin
            if (bus_if.done) begin got = 1; break; end
            if (!bus_if.busy) busy_ok = 0;
            lat++;
            @(negedge clk);
        end
        chk({name, " done seen"}, N'(got), N'(1));
        chk({name, " busy held"}, N'(busy_ok), N'(1));
        chk({name, " latency"}, N'(lat), N'(exp_lat));
        chk({name, " result"}, bus_if.result, exp_res);
        chk({name, " busy low at done"}, N'(bus_if.busy), N'(0));
        @(negedge clk);
        chk({name, " done pulse"}, N'(bus_if.done), N'(0));
    endtask

    // Count done pulses over a window; used where no done may appear.
    task automatic expect_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus_if.done) seen++;
        end
        chk(name, N'(seen), N'(0));
    endtask

    vec_t vecs[$];

    initial begin
        logic [N-1:0] all1;
        logic [N-1:0] prev;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rh;
        int           lat;
        bit           got;

        checks = 0;
        errors = 0;
        all1 = '1;

        vecs.push_back('{64'd3, 64'd5, 1'b0, 64'd15, 3});
        vecs.push_back('{64'hDEAD, 64'd0, 1'b0, 64'd0, 1});
        vecs.push_back('{all1, all1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64});
        vecs.push_back('{all1, all1, 1'b0, 64'd1, 64});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 3});
        vecs.push_back('{64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 64'd1, 33});
        vecs.push_back('{64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 64'd0, 33});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd2, 1'b1, 64'd1, 2});
        vecs.push_back('{64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 64});
        vecs.push_back('{64'd1, 64'd1, 1'b0, 64'd1, 1});

        bus_if.start = 0; bus_if.mulHigh = 0; bus_if.opA = '0; bus_if.opB = '0; bus_if.flush = 0;
        reset = 0;
        #12;
        chk("reset busy", N'(bus_if.busy), N'(0));
        chk("reset done", N'(bus_if.done), N'(0));
        chk("reset result", bus_if.result, N'(0));
        @(negedge clk);
        reset = 1;

        // Table-driven vectors
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi,
                   vecs[i].exp_res, vecs[i].exp_lat);

        // Reset mid-operation
        @(negedge clk);
        bus_if.start = 1; bus_if.opA = 64'd7; bus_if.opB = 64'hFF; bus_if.mulHigh = 0;
        @(negedge clk);
        bus_if.start = 0;
        @(negedge clk);
        chk("midrst busy before", N'(bus_if.busy), N'(1));
        reset = 0;
        #1;
        chk("midrst busy", N'(bus_if.busy), N'(0));
        chk("midrst done", N'(bus_if.done), N'(0));
        chk("midrst result", bus_if.result, N'(0));
        @(negedge clk);
        reset = 1;
        expect_no_done("midrst no done", 12);
        run_op("after rst", 64'd7, 64'hFF, 1'b0, 64'd1785, 8);

        // Flush in the third RUN cycle
        prev = bus_if.result;
        @(negedge clk);
        bus_if.start = 1; bus_if.opA = 64'd2; bus_if.opB = 64'h80; bus_if.mulHigh = 0;
        @(negedge clk);
        bus_if.start = 0;
        @(negedge clk);
        @(negedge clk);
        bus_if.flush = 1;
        @(negedge clk);
        bus_if.flush = 0;
        chk("flush busy", N'(bus_if.busy), N'(0));
        chk("flush done", N'(bus_if.done), N'(0));
        expect_no_done("flush no done", 12);
        chk("flush result kept", bus_if.result, prev);

        // Ignored start during RUN, then back-to-back from DONE
        @(negedge clk);
        bus_if.start = 1; bus_if.opA = 64'd4; bus_if.opB = 64'd4; bus_if.mulHigh = 0;
        @(negedge clk);
        bus_if.start = 1; bus_if.opA = 64'd9; bus_if.opB = 64'd9;
        @(negedge clk);
        bus_if.start = 0;
        got = 0; lat = 1;
        for (int c = 0; c < 20; c++) begin
            if (bus_if.done) begin got = 1; break; end
            lat++;
            @(negedge clk);
        end
        chk("b2b first done", N'(got), N'(1));
        chk("b2b first latency", N'(lat), N'(3));
        chk("b2b first result", bus_if.result, N'(16));
        bus_if.start = 1; bus_if.opA = 64'd6; bus_if.opB = 64'd7;
        @(negedge clk);
        bus_if.start = 0;
        chk("b2b busy rises", N'(bus_if.busy), N'(1));
        got = 0; lat = 1;
        for (int c = 0; c < 20; c++) begin
            if (bus_if.done) begin got = 1; break; end
            lat++;
            @(negedge clk);
        end
        chk("b2b second done", N'(got), N'(1));
        chk("b2b done spacing", N'(lat), N'(4));
        chk("b2b second result", bus_if.result, N'(42));

        // Flush together with start in DONE: done already showing, request refused
        bus_if.start = 1; bus_if.flush = 1; bus_if.opA = 64'd5; bus_if.opB = 64'd5;
        @(negedge clk);
        bus_if.start = 0; bus_if.flush = 0;
        chk("flush+start busy", N'(bus_if.busy), N'(0));
        expect_no_done("flush+start no done", 8);
        chk("flush+start result", bus_if.result, N'(42));

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, N - 1);
            if ((i % 7) == 0) rb = '0;
            rh = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rh, ref_result(ra, rb, rh), ref_lat(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end
endmodule
